// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: one-deep sample buffer, Philips framing with 32-bit slots,
// mono sample duplicated to both channels, BCLK/LRCLK derived from clk.
module i2s_tx_serializer #(
  parameter int WD       = 24,
  parameter int BCLK_DIV = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic [WD-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          underrun_clr,
  output logic          i2s_bclk,
  output logic          i2s_lrclk,
  output logic          i2s_sdata,
  output logic          frame_tick,
  output logic          underrun
);

  localparam int DW = $clog2(BCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [5:0] WD6 = 6'(WD);

  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [WD-1:0] buf_q;
  logic [WD-1:0] frame_q;

  logic          full;
  logic          tc;
  logic          fall;
  logic          load;
  logic          hs;
  logic [5:0]    bit_nxt;
  logic [4:0]    k;
  logic [WD-1:0] shifted;
  logic          sbit;

  assign full = ~in_ready;

  always_comb begin
    tc      = (div_cnt == DIV_LAST);
    fall    = en & tc & i2s_bclk;
    bit_nxt = bit_cnt + 6'd1;
    load    = fall & (bit_cnt == 6'd63);
    hs      = in_valid & in_ready;
    k       = bit_nxt[4:0];
    // Slot bit k carries frame[WD-k]; shifting left by k-1 puts it at the MSB.
    shifted = frame_q << (k - 5'd1);
    sbit    = 1'b0;
    if (k != 5'd0 && {1'b0, k} <= WD6)
      sbit = shifted[WD-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      bit_cnt    <= 6'd63;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b0;
      i2s_sdata  <= 1'b0;
      frame_tick <= 1'b0;
    end else if (!en) begin
      div_cnt    <= '0;
      bit_cnt    <= 6'd63;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b0;
      i2s_sdata  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= tc ? '0 : div_cnt + 1'b1;
      frame_tick <= load;
      if (tc)
        i2s_bclk <= ~i2s_bclk;
      if (fall) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= bit_nxt[5];
        i2s_sdata <= sbit;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q    <= '0;
      frame_q  <= '0;
      in_ready <= 1'b1;
    end else if (load && full) begin
      frame_q  <= buf_q;
      in_ready <= 1'b1;
    end else if (hs) begin
      buf_q    <= in_data;
      in_ready <= 1'b0;
    end
  end

  // An empty-buffer frame load wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      underrun <= 1'b0;
    else if (load && !full)
      underrun <= 1'b1;
    else if (underrun_clr)
      underrun <= 1'b0;
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Randomized scoreboard bench for i2s_tx_serializer: frame-level reference
// model, serial stream decoder and a cycle-accurate timing model.
module tb_i2s_tx_serializer;

  localparam int WD    = 24;
  localparam int DIV   = 16;
  localparam int FRAME = 128 * DIV;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic [WD-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          underrun_clr = 1'b0;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_sdata;
  logic          frame_tick;
  logic          underrun;

  logic          en2 = 1'b0;
  logic          rdy2, bclk2, lr2, sd2, tick2, und2;

  always #5 clk = ~clk;

  i2s_tx_serializer #(.WD(WD), .BCLK_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .underrun_clr(underrun_clr),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .frame_tick(frame_tick), .underrun(underrun)
  );

  i2s_tx_serializer #(.WD(WD), .BCLK_DIV(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .en(en2),
    .in_data('0), .in_valid(1'b0), .in_ready(rdy2),
    .underrun_clr(1'b0),
    .i2s_bclk(bclk2), .i2s_lrclk(lr2), .i2s_sdata(sd2),
    .frame_tick(tick2), .underrun(und2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames start every 128*DIV clocks, first at 2*DIV.
  int unsigned   cnt = 0;
  bit            m_full = 1'b0;
  bit            m_under = 1'b0;
  bit            m_tick = 1'b0;
  logic [WD-1:0] m_buf = '0;
  logic [WD-1:0] m_frame = '0;
  logic [WD-1:0] exp_q[$];

  always @(posedge clk or negedge reset_n) begin
    bit hs, ld;
    int unsigned m;
    if (!reset_n) begin
      cnt = 0; m_full = 0; m_under = 0; m_tick = 0;
      m_buf = '0; m_frame = '0;
      exp_q.delete();
    end else begin
      if (en) cnt++;
      else cnt = 0;
      m  = cnt / (2 * DIV);
      ld = en && cnt != 0 && (cnt % (2 * DIV)) == 0 && (m % 64) == 1;
      hs = in_valid && !m_full;
      if (ld && !m_full) m_under = 1;
      else if (underrun_clr) m_under = 0;
      if (ld) begin
        exp_q.push_back(m_full ? m_buf : m_frame);
        if (m_full) begin
          m_frame = m_buf;
          m_full = 0;
        end
      end
      if (hs) begin
        m_buf = in_data;
        m_full = 1;
      end
      m_tick = ld;
    end
  end

  always @(negedge clk) begin
    int unsigned m;
    bit eb, el;
    if (reset_n) begin
      m  = cnt / (2 * DIV);
      eb = ((cnt / DIV) % 2) == 1;
      el = m >= 1 && ((m + 63) % 64) >= 32;
      chk("ctl", {59'd0, i2s_bclk, i2s_lrclk, frame_tick, in_ready, underrun},
          {59'd0, eb, el, m_tick, !m_full, m_under});
    end
  end

  // Monitor: decode the serial stream on bclk rising edges.
  logic [63:0]   mbits, mlr;
  int            mon_n = 0;
  bit            mon_valid = 1'b0;
  bit            bclk_prev = 1'b0;
  logic [WD-1:0] cur = '0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset_n || !en) begin
      mon_valid = 0;
    end else begin
      if (frame_tick) begin
        if (mon_valid && mon_n == 64) begin
          e = 32'(cur);
          e = e << (31 - WD);
          chk("left_slot", {32'd0, mbits[63:32]}, {32'd0, e});
          chk("right_slot", {32'd0, mbits[31:0]}, {32'd0, e});
          chk("lrclk_bits", mlr, 64'h0000_0000_FFFF_FFFF);
        end
        chk("tick_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        mon_valid = 1;
        mon_n = 0;
      end
      if (i2s_bclk && !bclk_prev && mon_valid && mon_n < 64) begin
        mbits[63-mon_n] = i2s_sdata;
        mlr[63-mon_n]   = i2s_lrclk;
        mon_n++;
      end
    end
    bclk_prev = i2s_bclk;
  end

  task automatic send(input logic [WD-1:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 2 * FRAME + 100);
    chk("tick_seen", 64'(frame_tick), 64'd1);
  endtask

  task automatic pulse_clr();
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
  endtask

  initial begin
    int n;
    @(posedge reset_n);
    @(negedge clk);
    en2 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!tick2 && n < 1000);
    chk("div2_first_tick", 64'(n), 64'd4);
    repeat (3) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!tick2 && n < 1000);
      chk("div2_period", 64'(n), 64'd256);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_vals",
        {58'd0, i2s_bclk, i2s_lrclk, i2s_sdata, frame_tick, in_ready, underrun},
        64'b000010);
    reset_n = 1'b1;
    @(negedge clk);

    send(24'h800001);
    en = 1'b1;
    repeat (31) @(negedge clk);
    chk("tick_latency_pre", 64'(frame_tick), 64'd0);
    @(negedge clk);
    chk("tick_latency", 64'(frame_tick), 64'd1);

    send(24'h123456);
    send(24'hABCDEF);
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    wait_tick();

    send(24'h7FFFFF);
    wait_tick();
    wait_tick();
    chk("underrun_set", 64'(underrun), 64'd1);

    wait_tick();
    repeat (200) @(negedge clk);
    pulse_clr();
    chk("underrun_clr", 64'(underrun), 64'd0);
    repeat (FRAME - 1 - 201) @(negedge clk);
    pulse_clr();
    chk("clr_at_load_tick", 64'(frame_tick), 64'd1);
    chk("clr_vs_set", 64'(underrun), 64'd1);
    repeat (10) @(negedge clk);
    pulse_clr();
    chk("underrun_clr2", 64'(underrun), 64'd0);

    send(24'h5A5A5A);
    repeat (500) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en_low_pins", {61'd0, i2s_bclk, i2s_lrclk, i2s_sdata}, 64'd0);
    chk("en_low_buf_kept", 64'(in_ready), 64'd0);
    repeat (50) @(negedge clk);
    en = 1'b1;
    repeat (31) @(negedge clk);
    chk("reen_tick_pre", 64'(frame_tick), 64'd0);
    @(negedge clk);
    chk("reen_tick", 64'(frame_tick), 64'd1);
    chk("reen_loaded", 64'(in_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, FRAME + 500)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) pulse_clr();
      send(WD'($urandom()));
    end
    wait_tick();
    wait_tick();

    wait_tick();
    send(24'h13579B);
    repeat (40 * 2 * DIV - 2) @(negedge clk);
    chk("pre_reset_lr", 64'(i2s_lrclk), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset",
        {58'd0, i2s_bclk, i2s_lrclk, i2s_sdata, frame_tick, in_ready, underrun},
        64'b000010);
    @(negedge clk);
    reset_n = 1'b1;
    wait_tick();
    chk("post_reset_underrun", 64'(underrun), 64'd1);
    wait_tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Downstream stage of audio_equalizer.
- Takes the 24-bit mono sample stream from the equalizer's data_out through a valid/ready handshake.
- Serializes each sample as a standard I2S frame (Philips format, 32-bit slots, MSB-first, one-BCLK delay) and duplicates it to the left and right channels.
- Generates BCLK and LRCLK from the 100 MHz system clock.
- Drives the board audio DAC and emits a frame-rate tick to pace the upstream stage.

Parameters:
- WD, 24: sample width in bits; legal range 1..31.
- BCLK_DIV, 16: system clocks per BCLK half-period; minimum 2. At 100 MHz this gives BCLK 3.125 MHz and fs 48.83 kHz.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  serializer enable; low forces the idle state.
- in_data  input  WD  signed sample from the equalizer.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  holding buffer empty; the sample is accepted when in_valid && in_ready.
- underrun_clr  input  1  single-cycle pulse that clears the underrun flag.
- i2s_bclk  output  1  bit clock.
- i2s_lrclk  output  1  word select; 0 = left, 1 = right.
- i2s_sdata  output  1  serial data.
- frame_tick  output  1  one-clk pulse at each frame load.
- underrun  output  1  sticky flag: a frame started with the buffer empty.

Behaviour:
- Clocking and reset:
  - One clock domain; reset is asynchronous and active-low.
  - All outputs are registered.
- Reset values:
  - i2s_bclk, i2s_lrclk, i2s_sdata, frame_tick, underrun = 0; in_ready = 1.
  - Internal: div_cnt = 0, bit_cnt = 63, holding buffer empty, frame register = 0.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 while en = 1.
  - At the terminal count, div_cnt wraps and bclk toggles.
- Falling-edge actions: on the clk cycle where bclk toggles 1->0:
  - bit_cnt increments mod 64.
  - i2s_lrclk <= (new bit_cnt >= 32).
  - i2s_sdata is updated.
- Slot mapping, with k = bit_cnt mod 32:
  - k = 1..WD: sdata = frame[WD-k], MSB at k = 1.
  - k = 0 and k > WD: sdata = 0 (padding).
  - The same frame register feeds both slots.
- Frame load: when bit_cnt wraps 63 -> 0.
  - Buffer full: frame <= buffer, buffer emptied, frame_tick = 1 for that cycle.
  - Buffer empty: frame is retained (last sample repeated), underrun set, frame_tick still pulses.
- Holding buffer (one deep):
  - in_ready = ~full.
  - On a handshake, the buffer captures in_data and in_ready drops the next cycle.
  - Frame load while full: the buffer empties and in_ready returns to 1 the next cycle. No same-cycle refill is possible because in_ready was 0.
  - Handshake in the same cycle as a frame load with the buffer empty: the frame load counts as an underrun and the new sample waits for the next frame.
- Underrun flag:
  - Cleared by underrun_clr.
  - A set and a clear in the same cycle resolve to set.
- Start-up latency: from en rising with counters at reset state:
  - bclk first rises at clk BCLK_DIV.
  - First falling edge and frame_tick at clk 2*BCLK_DIV (32 at default).
  - Left MSB appears at the next falling edge.
- Frame period: 128*BCLK_DIV clocks (2048 at default). bclk and lrclk have 50% duty.
- en low:
  - Counters return to reset values; bclk, lrclk and sdata go to 0.
  - Buffer contents and underrun are preserved; the handshake stays active.
- Reset mid-operation: all state returns to reset values immediately, regardless of clk. Any buffered sample is discarded.
- Arithmetic: none. The two's-complement bit pattern passes through unchanged.

Test Plan:
- Reset: assert reset_n low mid-frame at bit_cnt = 40 -> outputs go to reset values without a clk edge; in_ready = 1; underrun = 0.
- Single sample: write 0x800001, raise en -> frame_tick at clk 32; sdata sampled on bclk rising edges yields 0x800001 in both slots; slot bits 0 and 25..31 are 0; lrclk toggles every 32 bclk periods.
- Backpressure: write 0x123456 then hold in_valid with 0xABCDEF -> in_ready stays 0 until the cycle after the next frame_tick; 0xABCDEF is captured and transmitted in the following frame.
- Underrun: no write for one frame after 0x7FFFFF -> 0x7FFFFF repeats and underrun = 1; underrun_clr pulsed in the same cycle as a new underrun -> underrun stays 1; a clear with no underrun -> 0.
- Timing: BCLK_DIV = 16 -> bclk period 32 clk, frame_tick period 2048 clk, lrclk changes exactly on bclk falling edges; repeat with BCLK_DIV = 2 -> period 256 clk.
- Enable gating: drop en mid-frame -> bclk, lrclk and sdata are 0 the next cycle; the buffered sample survives; re-raising en gives the first frame_tick after 2*BCLK_DIV clk and loads the buffered sample.
